// File: rtl/mcm_rand_feeder_pkg.sv
// Shared types and constants for the masked-multiplier random feeder.
// Holds the masking order, reduced-polynomial entry type and LFSR constants.
package mcm_rand_feeder_pkg;

   localparam int d = 2;

   typedef logic [7:0] red_poly_t;

   localparam int          N_RAND       = 2 * (8 + d);
   localparam int          RAND_W       = $bits(red_poly_t);
   localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
   localparam logic [63:0] DEF_ZERO_SUB = 64'h1;

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      FILL     = 2'd1,
      FULL     = 2'd2
   } rng_state_e;

endpackage

// File: rtl/mcm_rand_feeder_lfsr_step_n.sv
// N unrolled steps of a right-shifting 64-bit Galois LFSR.
// Purely combinational so it can be exercised on its own.
module lfsr_step_n
   import mcm_rand_feeder_pkg::*;
#(
   parameter int          N    = RAND_W,
   parameter logic [63:0] TAPS = LFSR_TAPS
) (
   input  logic [63:0] state,
   output logic [63:0] stepped
);

   always_comb begin
      stepped = state;
      for (int i = 0; i < N; i++) begin
         // Feedback bit is the lsb shifted out; it folds the taps back in.
         if (stepped[0]) begin
            stepped = (stepped >> 1) ^ TAPS;
         end else begin
            stepped = stepped >> 1;
         end
      end
   end

endmodule

// File: rtl/mcm_rand_feeder.sv
// Random-vector feeder: an LFSR fills a shadow buffer one entry per cycle and a
// take publishes the whole buffer to a held output vector (entry i at slice i).
module mcm_rand_feeder
   import mcm_rand_feeder_pkg::*;
#(
   parameter int          N_ENT    = N_RAND,
   parameter int          RED_W    = RAND_W,
   parameter logic [63:0] ZERO_SUB = DEF_ZERO_SUB
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   seed_ld,
   input  logic [63:0]            seed,
   input  logic                   take_i,
   output logic                   rdy_o,
   output logic                   underrun_o,
   output logic [N_ENT*RED_W-1:0] random_vect
);

   localparam int               CNT_W    = (N_ENT > 1) ? $clog2(N_ENT) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ENT - 1);

   rng_state_e       state_reg, state_next;
   logic [63:0]      lfsr_reg;
   logic [63:0]      lfsr_stepped;
   logic [CNT_W-1:0] fill_cnt_reg;
   logic [RED_W-1:0] shadow_reg [N_ENT];
   logic [RED_W-1:0] vect_reg   [N_ENT];
   logic             publish;
   logic             shadow_we;
   logic             underrun_next;

   lfsr_step_n #(
      .N    (RED_W),
      .TAPS (LFSR_TAPS)
   ) u_step (
      .state   (lfsr_reg),
      .stepped (lfsr_stepped)
   );

   always_comb begin
      state_next    = state_reg;
      publish       = 1'b0;
      shadow_we     = 1'b0;
      underrun_next = take_i && (state_reg != FULL);
      case (state_reg)
         UNSEEDED: begin
            if (seed_ld) state_next = FILL;
         end
         FILL: begin
            // A reseed restarts the fill, so the current entry is not written.
            shadow_we = !seed_ld;
            if (!seed_ld && fill_cnt_reg == LAST_IDX) state_next = FULL;
         end
         FULL: begin
            publish = take_i;
            if (take_i || seed_ld) state_next = FILL;
         end
         default: state_next = UNSEEDED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= UNSEEDED;
         lfsr_reg     <= 64'd0;
         fill_cnt_reg <= '0;
         underrun_o   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         underrun_o <= underrun_next;
         if (seed_ld) begin
            lfsr_reg     <= (seed == 64'd0) ? ZERO_SUB : seed;
            fill_cnt_reg <= '0;
         end else if (shadow_we) begin
            lfsr_reg     <= lfsr_stepped;
            fill_cnt_reg <= (fill_cnt_reg == LAST_IDX) ? '0 : fill_cnt_reg + 1'b1;
         end else if (publish) begin
            fill_cnt_reg <= '0;
         end
      end
   end

   // Published vector only moves on a successful take, never during a fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ENT; i++) begin
            shadow_reg[i] <= '0;
            vect_reg[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_ENT; i++) begin
            if (shadow_we && fill_cnt_reg == CNT_W'(i)) shadow_reg[i] <= lfsr_stepped[RED_W-1:0];
            if (publish) vect_reg[i] <= shadow_reg[i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_ENT; gi++) begin : g_flat
         assign random_vect[gi*RED_W +: RED_W] = vect_reg[gi];
      end
   endgenerate

   assign rdy_o = (state_reg == FULL);

endmodule

// File: tb/tb_mcm_rand_feeder.sv
// Directed self-checking bench for mcm_rand_feeder with a golden LFSR model
// and a queue of expected published vectors.
module tb_mcm_rand_feeder;
   import mcm_rand_feeder_pkg::*;

   localparam int VW = N_RAND * RAND_W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          seed_ld = 1'b0;
   logic [63:0]   seed = 64'd0;
   logic          take_i = 1'b0;
   logic          rdy_o;
   logic          underrun_o;
   logic [VW-1:0] random_vect;

   int n_checks = 0;
   int n_errors = 0;
   logic [VW-1:0] exp_q [$];

   mcm_rand_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .seed_ld     (seed_ld),
      .seed        (seed),
      .take_i      (take_i),
      .rdy_o       (rdy_o),
      .underrun_o  (underrun_o),
      .random_vect (random_vect)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Golden model: one bit-serial Galois step per shift, RAND_W shifts per entry.
   function automatic void gfill(input logic [63:0] start, output logic [VW-1:0] v,
                                 output logic [63:0] fin);
      logic [63:0] s;
      logic        fb;
      s = start;
      v = '0;
      for (int e = 0; e < N_RAND; e++) begin
         for (int b = 0; b < RAND_W; b++) begin
            fb = s[0];
            s  = {1'b0, s[63:1]};
            if (fb) s = s ^ 64'hD800_0000_0000_0000;
         end
         v[e*RAND_W +: RAND_W] = s[RAND_W-1:0];
      end
      fin = s;
   endfunction

   // Counts edges until rdy_o, checking the published vector holds meanwhile.
   task automatic wait_rdy(input string tag, input int exp_edges, input logic [VW-1:0] hold);
      int n;
      n = 0;
      while (!rdy_o && n < 100) begin
         tick();
         n++;
         chk({tag, "_hold"}, random_vect, hold);
      end
      chk({tag, "_fill_edges"}, VW'(n), VW'(exp_edges));
      $display("wait_rdy %s: rdy after %0d edges", tag, n);
   endtask

   // Successful take from FULL; optionally with a simultaneous reseed.
   task automatic do_take(input string tag, input logic [VW-1:0] exp_v,
                          input logic with_seed, input logic [63:0] sv);
      logic [VW-1:0] e;
      exp_q.push_back(exp_v);
      take_i  = 1'b1;
      seed_ld = with_seed;
      seed    = sv;
      tick();
      take_i  = 1'b0;
      seed_ld = 1'b0;
      e = exp_q.pop_front();
      chk({tag, "_vect"}, random_vect, e);
      chk({tag, "_rdy_low"}, VW'(rdy_o), VW'(0));
      chk({tag, "_no_underrun"}, VW'(underrun_o), VW'(0));
      $display("take %s: vect=%0h", tag, random_vect);
   endtask

   task automatic do_seed(input logic [63:0] sv);
      seed_ld = 1'b1;
      seed    = sv;
      tick();
      seed_ld = 1'b0;
      $display("seed_ld %0h", sv);
   endtask

   initial begin
      logic [VW-1:0] va, vb, vc, vd, ve, held;
      logic [63:0]   s;

      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset_rdy", VW'(rdy_o), VW'(0));
      chk("reset_underrun", VW'(underrun_o), VW'(0));
      chk("reset_vect", random_vect, '0);

      take_i = 1'b1;
      tick();
      take_i = 1'b0;
      chk("unseeded_underrun", VW'(underrun_o), VW'(1));
      chk("unseeded_vect", random_vect, '0);
      tick();
      chk("unseeded_underrun_clear", VW'(underrun_o), VW'(0));
      chk("unseeded_rdy", VW'(rdy_o), VW'(0));

      // seed=1 first fill
      gfill(64'h1, va, s);
      do_seed(64'h1);
      wait_rdy("seed1", N_RAND, '0);
      do_take("seed1", va, 1'b0, 64'd0);
      gfill(s, vb, s);
      wait_rdy("second", N_RAND, va);
      do_take("second", vb, 1'b0, 64'd0);
      chk("second_differs", VW'(random_vect != va), VW'(1));

      // seed=0 substitutes 1: identical contents and timing
      rst = 1'b1;
      tick();
      rst = 1'b0;
      gfill(64'h1, va, s);
      do_seed(64'h0);
      wait_rdy("seed0", N_RAND, '0);
      do_take("seed0", va, 1'b0, 64'd0);

      // bad take at fill cycle 5
      gfill(s, vb, s);
      repeat (4) tick();
      take_i = 1'b1;
      tick();
      take_i = 1'b0;
      chk("fill_underrun", VW'(underrun_o), VW'(1));
      chk("fill_underrun_vect", random_vect, va);
      tick();
      chk("fill_underrun_pulse", VW'(underrun_o), VW'(0));
      wait_rdy("after_underrun", N_RAND - 6, va);
      do_take("after_underrun", vb, 1'b0, 64'd0);

      // simultaneous take + reseed in FULL
      gfill(s, vc, s);
      wait_rdy("pre_both", N_RAND, vb);
      gfill(64'hDEAD_BEEF_0BAD_F00D, vd, s);
      do_take("take_seed", vc, 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
      wait_rdy("post_both", N_RAND, vc);
      do_take("post_both", vd, 1'b0, 64'd0);

      // reseed at fill cycle 10
      repeat (9) tick();
      gfill(64'h0123_4567_89AB_CDEF, ve, s);
      do_seed(64'h0123_4567_89AB_CDEF);
      wait_rdy("reseed", N_RAND, vd);
      do_take("reseed", ve, 1'b0, 64'd0);

      // reset mid-fill
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_vect", random_vect, '0);
      chk("mid_rst_rdy", VW'(rdy_o), VW'(0));
      chk("mid_rst_underrun", VW'(underrun_o), VW'(0));
      take_i = 1'b1;
      tick();
      take_i = 1'b0;
      chk("post_rst_underrun", VW'(underrun_o), VW'(1));
      held = random_vect;
      repeat (N_RAND + 5) tick();
      chk("post_rst_idle_rdy", VW'(rdy_o), VW'(0));
      chk("post_rst_idle_vect", random_vect, '0);
      chk("post_rst_held", random_vect, held);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
